// File: rtl/pose_engine_pkg.sv
// Shared fixed-point parameters, Q-format type and FSM state encoding for the pose engine.
// No logic of its own.
// The real-valued conversions are only for simulation and debug and are not used in RTL.
`ifndef POSE_ENGINE_F_MACRO
`define POSE_ENGINE_F_MACRO
`define F pose_engine_pkg::fix_t
`endif

package pose_engine_pkg;
  localparam int QM  = 12;
  localparam int QN  = 12;
  localparam int W   = QM + QN;
  localparam int ONE = 1 << QN;

  typedef logic signed [W-1:0] fix_t;

  // Each state is named after the step it performs on the edge that leaves it.
  // The speed (SPD) step runs on the tick edge itself, while the FSM is still in IDLE.
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_MX     = 4'd1;
  localparam logic [3:0] ST_MY     = 4'd2;
  localparam logic [3:0] ST_R1     = 4'd3;
  localparam logic [3:0] ST_R2     = 4'd4;
  localparam logic [3:0] ST_R3     = 4'd5;
  localparam logic [3:0] ST_R4     = 4'd6;
  localparam logic [3:0] ST_R5     = 4'd7;
  localparam logic [3:0] ST_R6     = 4'd8;
  localparam logic [3:0] ST_R7     = 4'd9;
  localparam logic [3:0] ST_R8     = 4'd10;
  localparam logic [3:0] ST_COMMIT = 4'd11;

  function automatic real Freal(input fix_t v);
    return $itor(v) / $itor(ONE);
  endfunction

  function automatic fix_t realF(input real r);
    return fix_t'($rtoi(r * $itor(ONE)));
  endfunction
endpackage

// File: rtl/pose_engine_fx_mul.sv
// Combinational signed QM.QN multiply: (a*b) >>> QN, truncated to W bits (floor, wraps on overflow).
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module pose_engine_fx_mul
  import pose_engine_pkg::*;
(
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_p
);
  logic signed [2*W-1:0] w_a_ext;
  logic signed [2*W-1:0] w_b_ext;
  logic signed [2*W-1:0] w_full;
  logic signed [2*W-1:0] w_shr;
  logic                  w_unused;

  assign w_a_ext  = {{W{i_a[W-1]}}, i_a};
  assign w_b_ext  = {{W{i_b[W-1]}}, i_b};
  assign w_full   = w_a_ext * w_b_ext;
  assign w_shr    = w_full >>> QN;
  assign o_p      = w_shr[W-1:0];
  // The high product bits are deliberately dropped: the result wraps on overflow.
  assign w_unused = ^w_shr[2*W-1:W];
endmodule

// File: rtl/pose_engine.sv
// Player pose engine: once per tick, facing-relative motion plus rotation through one shared multiplier.
// Latency: 12 clocks from the tick edge for a motion update; 1 clock for a pending host load.
// Backpressure: load_ready drops while a host pose is pending; a tick that arrives while busy is dropped and pulses overrun.
// POSE_CLAMP_EN: when defined, committed positions saturate to [POS_MIN, POS_MAX]; when undefined they wrap.
module pose_engine
  import pose_engine_pkg::*;
#(
  parameter int WALK_SPEED = 80,
  parameter int RUN_SPEED  = 144,
  parameter int DIAG_SCALE = 2896,
  parameter int ROT_COS    = 4091,
  parameter int ROT_SIN    = 201,
  parameter int POS_MIN    = 0,
  parameter int POS_MAX    = 65535,
  parameter int START_PX   = 6144,
  parameter int START_PY   = 55296,
  parameter int START_FX   = 0,
  parameter int START_FY   = -4096,
  parameter int START_VX   = 2048,
  parameter int START_VY   = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         move_f,
  input  logic         move_b,
  input  logic         move_l,
  input  logic         move_r,
  input  logic         rot_l,
  input  logic         rot_r,
  input  logic         run,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [W-1:0] load_px,
  input  logic [W-1:0] load_py,
  input  logic [W-1:0] load_fx,
  input  logic [W-1:0] load_fy,
  input  logic [W-1:0] load_vx,
  input  logic [W-1:0] load_vy,
  output logic [W-1:0] player_x,
  output logic [W-1:0] player_y,
  output logic [W-1:0] facing_x,
  output logic [W-1:0] facing_y,
  output logic [W-1:0] vplane_x,
  output logic [W-1:0] vplane_y,
  output logic         busy,
  output logic         update_done,
  output logic         overrun
);
  localparam fix_t C_WALK = fix_t'(WALK_SPEED);
  localparam fix_t C_RUN  = fix_t'(RUN_SPEED);
  localparam fix_t C_DIAG = fix_t'(DIAG_SCALE);
  localparam fix_t C_COS  = fix_t'(ROT_COS);
  localparam fix_t C_SIN  = fix_t'(ROT_SIN);
  localparam fix_t C_ONE  = fix_t'(ONE);
  localparam logic signed [W+1:0] P_MIN = (W+2)'(POS_MIN);
  localparam logic signed [W+1:0] P_MAX = (W+2)'(POS_MAX);

  logic [3:0] r_state;
  `F r_px, r_py, r_fx, r_fy, r_vx, r_vy;
  `F r_sh_px, r_sh_py, r_sh_fx, r_sh_fy, r_sh_vx, r_sh_vy;
  logic r_pending;
  `F r_sp, r_ax, r_ay, r_nfx, r_nfy, r_nvx, r_nvy, r_rs, r_rc;
  logic r_f_pos, r_f_neg, r_s_pos, r_s_neg;
  logic r_done, r_ovr;

  logic w_load_acc, w_load_commit, w_start, w_diag;
  `F w_base_sp, w_rot_s, w_rot_c, w_ma, w_mb, w_mp;
  logic signed [W+1:0] w_ax_e, w_ay_e, w_px_e, w_py_e;
  logic signed [W+1:0] w_fwd_ax, w_fwd_ay, w_str_ax, w_str_ay, w_sum_x, w_sum_y;
  `F w_new_px, w_new_py;

  assign load_ready    = !r_pending;
  assign w_load_acc    = load_valid && !r_pending;
  assign w_load_commit = tick && (r_state == ST_IDLE) && r_pending;
  assign w_start       = tick && (r_state == ST_IDLE) && !r_pending;

  // Request decode at the tick: forward beats back, left beats right, rot_l beats rot_r.
  assign w_diag    = (move_f || move_b) && (move_l || move_r);
  assign w_base_sp = run ? C_RUN : C_WALK;
  assign w_rot_s   = rot_l ? -C_SIN : (rot_r ? C_SIN : '0);
  assign w_rot_c   = (rot_l || rot_r) ? C_COS : C_ONE;

  // Route the single multiplier's operands according to the step in progress.
  always_comb begin
    w_ma = r_sp;
    w_mb = r_fx;
    case (r_state)
      ST_IDLE: begin w_ma = w_base_sp; w_mb = C_DIAG; end
      ST_MX:   begin w_ma = r_sp;      w_mb = r_fx;   end
      ST_MY:   begin w_ma = r_sp;      w_mb = r_fy;   end
      ST_R1:   begin w_ma = r_fx;      w_mb = r_rc;   end
      ST_R2:   begin w_ma = r_fy;      w_mb = r_rs;   end
      ST_R3:   begin w_ma = r_fx;      w_mb = r_rs;   end
      ST_R4:   begin w_ma = r_fy;      w_mb = r_rc;   end
      ST_R5:   begin w_ma = r_vx;      w_mb = r_rc;   end
      ST_R6:   begin w_ma = r_vy;      w_mb = r_rs;   end
      ST_R7:   begin w_ma = r_vx;      w_mb = r_rs;   end
      ST_R8:   begin w_ma = r_vy;      w_mb = r_rc;   end
      default: begin w_ma = r_sp;      w_mb = r_fx;   end
    endcase
  end

  pose_engine_fx_mul u_mul (
    .i_a (w_ma),
    .i_b (w_mb),
    .o_p (w_mp)
  );

  // The position update is evaluated two bits wider than W, so that the clamp can see the true sum.
  // Strafe direction is (-facing_y, facing_x).
  assign w_ax_e   = {{2{r_ax[W-1]}}, r_ax};
  assign w_ay_e   = {{2{r_ay[W-1]}}, r_ay};
  assign w_px_e   = {{2{r_px[W-1]}}, r_px};
  assign w_py_e   = {{2{r_py[W-1]}}, r_py};
  assign w_fwd_ax = r_f_pos ? w_ax_e : (r_f_neg ? -w_ax_e : '0);
  assign w_fwd_ay = r_f_pos ? w_ay_e : (r_f_neg ? -w_ay_e : '0);
  assign w_str_ax = r_s_pos ? w_ax_e : (r_s_neg ? -w_ax_e : '0);
  assign w_str_ay = r_s_pos ? w_ay_e : (r_s_neg ? -w_ay_e : '0);
  assign w_sum_x  = w_px_e + w_fwd_ax - w_str_ay;
  assign w_sum_y  = w_py_e + w_fwd_ay + w_str_ax;

`ifdef POSE_CLAMP_EN
  // Saturate the committed position into the legal window.
  always_comb begin
    w_new_px = w_sum_x[W-1:0];
    w_new_py = w_sum_y[W-1:0];
    if (w_sum_x < P_MIN)      w_new_px = P_MIN[W-1:0];
    else if (w_sum_x > P_MAX) w_new_px = P_MAX[W-1:0];
    if (w_sum_y < P_MIN)      w_new_py = P_MIN[W-1:0];
    else if (w_sum_y > P_MAX) w_new_py = P_MAX[W-1:0];
  end
`else
  logic w_unused;
  assign w_new_px = w_sum_x[W-1:0];
  assign w_new_py = w_sum_y[W-1:0];
  assign w_unused = ^{w_sum_x[W+1:W], w_sum_y[W+1:W], P_MIN, P_MAX};
`endif

  // Shadow pose: capture the host pose on a handshake; it stays pending until a tick commits it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= 1'b0;
      r_sh_px <= '0; r_sh_py <= '0; r_sh_fx <= '0;
      r_sh_fy <= '0; r_sh_vx <= '0; r_sh_vy <= '0;
    end else begin
      if (w_load_commit) r_pending <= 1'b0;
      if (w_load_acc) begin
        r_pending <= 1'b1;
        r_sh_px <= load_px; r_sh_py <= load_py; r_sh_fx <= load_fx;
        r_sh_fy <= load_fy; r_sh_vx <= load_vx; r_sh_vy <= load_vy;
      end
    end
  end

  // Update sequencer: one multiply per step, with all six pose registers written together at the end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_px <= fix_t'(START_PX); r_py <= fix_t'(START_PY);
      r_fx <= fix_t'(START_FX); r_fy <= fix_t'(START_FY);
      r_vx <= fix_t'(START_VX); r_vy <= fix_t'(START_VY);
      r_sp <= '0; r_ax <= '0; r_ay <= '0;
      r_nfx <= '0; r_nfy <= '0; r_nvx <= '0; r_nvy <= '0;
      r_rs <= '0; r_rc <= '0;
      r_f_pos <= 1'b0; r_f_neg <= 1'b0; r_s_pos <= 1'b0; r_s_neg <= 1'b0;
      r_done <= 1'b0; r_ovr <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ovr  <= tick && (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_load_commit) begin
            r_px <= r_sh_px; r_py <= r_sh_py; r_fx <= r_sh_fx;
            r_fy <= r_sh_fy; r_vx <= r_sh_vx; r_vy <= r_sh_vy;
            r_done <= 1'b1;
          end else if (w_start) begin
            r_f_pos <= move_f;
            r_f_neg <= !move_f && move_b;
            r_s_neg <= move_l;
            r_s_pos <= !move_l && move_r;
            r_rs    <= w_rot_s;
            r_rc    <= w_rot_c;
            r_sp    <= w_diag ? w_mp : w_base_sp;
            r_state <= ST_MX;
          end
        end
        ST_MX: begin r_ax  <= w_mp;         r_state <= ST_MY; end
        ST_MY: begin r_ay  <= w_mp;         r_state <= ST_R1; end
        ST_R1: begin r_nfx <= w_mp;         r_state <= ST_R2; end
        ST_R2: begin r_nfx <= r_nfx - w_mp; r_state <= ST_R3; end
        ST_R3: begin r_nfy <= w_mp;         r_state <= ST_R4; end
        ST_R4: begin r_nfy <= r_nfy + w_mp; r_state <= ST_R5; end
        ST_R5: begin r_nvx <= w_mp;         r_state <= ST_R6; end
        ST_R6: begin r_nvx <= r_nvx - w_mp; r_state <= ST_R7; end
        ST_R7: begin r_nvy <= w_mp;         r_state <= ST_R8; end
        ST_R8: begin r_nvy <= r_nvy + w_mp; r_state <= ST_COMMIT; end
        ST_COMMIT: begin
          r_px <= w_new_px; r_py <= w_new_py;
          r_fx <= r_nfx;    r_fy <= r_nfy;
          r_vx <= r_nvx;    r_vy <= r_nvy;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign player_x    = r_px;
  assign player_y    = r_py;
  assign facing_x    = r_fx;
  assign facing_y    = r_fy;
  assign vplane_x    = r_vx;
  assign vplane_y    = r_vy;
  assign busy        = (r_state != ST_IDLE);
  assign update_done = r_done;
  assign overrun     = r_ovr;
endmodule
